nibble_serial_alu_seq: RTL and testbench
========================================

NIBBLE_SERIAL_ALU_SEQ -- requirements
Module: nibble_serial_alu_seq

Parameters
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2: the number of wait cycles per nibble for the combinational 4-bit add/sub stage to settle.
REQ-002 The block SHALL have parameter NIBBLES, default 4: the number of 4-bit slices per operand, giving an operand width of 4*NIBBLES.

Interface
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 op_a  in  4*NIBBLES  operand A.
REQ-008 op_b  in  4*NIBBLES  operand B.
REQ-009 op_sel  in  2  selects the B-path term: 00 = B, 01 = ~B, 10 = 0, 11 = all-ones.
REQ-010 op_cin  in  1  carry-in to the least significant nibble.
REQ-011 add_a  out  4  A nibble driven to the add/sub stage.
REQ-012 add_b  out  4  B nibble driven to the add/sub stage.
REQ-013 add_s  out  2  op_sel driven to the add/sub stage.
REQ-014 add_cin  out  1  nibble carry-in driven to the add/sub stage.
REQ-015 add_d  in  4  nibble sum returned by the stage.
REQ-016 add_cout  in  1  nibble carry returned by the stage.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  consumer accepts the result.
REQ-019 res_sum  out  4*NIBBLES  assembled result.
REQ-020 res_cout  out  1  carry out of the most significant nibble.

Function
REQ-021 The FSM SHALL have states IDLE, SETTLE, CAPTURE and DONE.
REQ-022 in_ready SHALL be 1 only in IDLE.
- Accept occurs on in_valid=1 and in_ready=1.
- At accept, op_a, op_b, op_sel and op_cin are registered; later input changes are ignored.
REQ-023 On accept, the FSM SHALL go IDLE->SETTLE with nibble index 0.
- add_a/add_b = nibble 0 of the registered operands.
- add_s = registered op_sel.
- add_cin = registered op_cin.
REQ-024 SETTLE SHALL hold the add_* outputs stable for exactly SETTLE_CYC cycles, counted by a down-counter, then go to CAPTURE.
REQ-025 In CAPTURE (1 cycle), the block SHALL:
- write add_d into res_sum[4k+3:4k], where k is the nibble index;
- store add_cout as the next carry.
REQ-026 From CAPTURE, if k < NIBBLES-1, the FSM SHALL:
- increment k;
- drive nibble k+1 with add_cin = the stored carry;
- return to SETTLE.
Otherwise it SHALL go to DONE with res_cout = the stored carry.
REQ-027 The latency from the accept edge to res_valid=1 SHALL be exactly NIBBLES*(SETTLE_CYC+1) cycles (12 at defaults).
REQ-028 add_s SHALL stay constant for all nibbles of one operation; there is no per-nibble re-inversion.
REQ-029 In DONE, res_valid SHALL be 1 and res_sum/res_cout stable until res_ready=1.
- On res_ready=1, the FSM goes to IDLE and res_valid falls the next cycle.
- A new accept is possible in the cycle after that.
REQ-030 in_valid asserted outside IDLE SHALL be ignored; no queuing.
REQ-031 In IDLE, add_a, add_b and add_cin SHALL be 0, and add_s SHALL keep its last value.
REQ-032 Arithmetic SHALL be modulo 2^(4*NIBBLES), with the overflow bit reported only via res_cout.
REQ-033 All outputs SHALL be register-driven; there is no combinational path from any input to any output.

Reset
REQ-034 Asserting rst_n=0 at any time, including mid-operation, SHALL immediately force:
- state IDLE, k=0, counter=0;
- in_ready=1;
- res_valid=0, res_sum=0, res_cout=0;
- add_a=0, add_b=0, add_s=00, add_cin=0.
REQ-035 The first accept after reset release SHALL be possible at the first rising edge with rst_n=1.

Verification (defaults, add/sub stage model connected)
REQ-036 Add: A=0x1234, B=0x0FFF, sel=00, cin=0 -> res_sum=0x2233, res_cout=0; res_valid exactly 12 cycles after accept; per-nibble add_cin sequence 0,1,1,1.
REQ-037 Subtract: A=0x0005, B=0x0007, sel=01, cin=1 -> res_sum=0xFFFE, res_cout=0; A=0x0007, B=0x0005 -> 0x0002, res_cout=1.
REQ-038 Increment wrap: A=0xFFFF, sel=10, cin=1 -> res_sum=0x0000, res_cout=1; decrement: A=0x0000, sel=11, cin=0 -> 0xFFFF, res_cout=0.
REQ-039 Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, res_sum and res_cout unchanged and in_ready=0 throughout; second in_valid pulse ignored; result drops 1 cycle after res_ready=1.
REQ-040 Mid-operation reset: drop rst_n during nibble 2 SETTLE -> all outputs at reset values asynchronously; after release, A=0x00FF, B=0x0001, sel=00, cin=0 -> 0x0100, res_cout=0.
REQ-041 Operand stability: change op_a/op_b every cycle after accept -> result reflects only the values sampled at accept.

Source files
------------

// File: rtl/nibble_serial_alu_seq.sv
// Nibble-serial ALU sequencer: feeds one 4-bit slice at a time to an external
// add/sub stage, waits for it to settle, captures the slice and chains the carry.
module nibble_serial_alu_seq #(
  parameter int SETTLE_CYC = 2,
  parameter int NIBBLES    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [1:0]           op_sel,
  input  logic                 op_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic [1:0]           add_s,
  output logic                 add_cin,
  input  logic [3:0]           add_d,
  input  logic                 add_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic            in_ready_q, in_ready_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic [3:0]      add_a_q, add_a_d, add_b_q, add_b_d;
  logic [1:0]      add_s_q, add_s_d;
  logic            add_cin_q, add_cin_d;

  // Operands are held in shift registers so the next slice is always bits [3:0];
  // add_cin_q doubles as the stored inter-nibble carry.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_s_d     = add_s_q;
    add_cin_d   = add_cin_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SETTLE;
          k_d       = '0;
          cnt_d     = CNT_LOAD;
          add_a_d   = op_a[3:0];
          add_b_d   = op_b[3:0];
          add_s_d   = op_sel;
          add_cin_d = op_cin;
          a_sh_d    = op_a >> 4;
          b_sh_d    = op_b >> 4;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CAPTURE: begin
        res_sum_d[4*int'(k_q) +: 4] = add_d;
        if (k_q == K_LAST) begin
          state_d     = DONE;
          res_cout_d  = add_cout;
          res_valid_d = 1'b1;
          add_a_d     = '0;
          add_b_d     = '0;
          add_cin_d   = 1'b0;
        end else begin
          state_d   = SETTLE;
          k_d       = k_q + KW'(1);
          cnt_d     = CNT_LOAD;
          add_a_d   = a_sh_q[3:0];
          add_b_d   = b_sh_q[3:0];
          add_cin_d = add_cout;
          a_sh_d    = a_sh_q >> 4;
          b_sh_d    = b_sh_q >> 4;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_s_q     <= '0;
      add_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_s_q     <= add_s_d;
      add_cin_q   <= add_cin_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_s     = add_s_q;
  assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Scoreboard bench for nibble_serial_alu_seq with a behavioural 4-bit add/sub stage.
module tb_nibble_serial_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0, op_b = '0;
  logic [1:0]  op_sel = '0;
  logic        op_cin = 1'b0;
  logic [3:0]  add_a, add_b, add_d;
  logic [1:0]  add_s;
  logic        add_cin, add_cout;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_sum;
  logic        res_cout;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  nibble_serial_alu_seq #(.SETTLE_CYC(2), .NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cin(add_cin),
    .add_d(add_d), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Add/sub stage model
  logic [3:0] bterm;
  always_comb begin
    case (add_s)
      2'b00:   bterm = add_b;
      2'b01:   bterm = ~add_b;
      2'b10:   bterm = 4'h0;
      default: bterm = 4'hF;
    endcase
    {add_cout, add_d} = {1'b0, add_a} + {1'b0, bterm} + {4'b0, add_cin};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of res_valid, data on handshake
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (res_valid && !prev_v) begin
          if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
          else                chk("latency", cyc, sb[0].cyc);
        end
        if (res_valid && res_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("res_sum", res_sum, e.sum);
          chk("res_cout", res_cout, e.cout);
        end
      end
      prev_v = res_valid;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                       input logic cin, input logic [15:0] esum, input logic ecout,
                       output int acc);
    exp_t e;
    bit ok;
    @(posedge clk) #1;
    op_a = a; op_b = b; op_sel = sel; op_cin = cin; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    e.sum = esum; e.cout = ecout; e.cyc = acc + 12;
    sb.push_back(e);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [15:0] a;
    exp_t e;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_add_s", add_s, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Add with nibble carry chain
    a = 16'h1234;
    issue(a, 16'h0FFF, 2'b00, 1'b0, 16'h2233, 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) @(negedge clk);
      else        repeat (3) @(negedge clk);
      chk("nib_cyc", cyc, acc + 3 * k);
      chk("add_a_nib", add_a, a[4*k +: 4]);
      chk("add_s_const", add_s, 2'b00);
      chk("add_cin_seq", add_cin, (k == 0) ? 0 : 1);
    end
    drain();
    chk("idle_add_a", add_a, 0);
    chk("idle_add_cin", add_cin, 0);

    // Subtract, increment wrap, decrement, full carry
    issue(16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, acc);
    drain();
    chk("idle_add_s_kept", add_s, 2'b01);
    issue(16'h0007, 16'h0005, 2'b01, 1'b1, 16'h0002, 1'b1, acc);
    drain();
    issue(16'hFFFF, 16'h1234, 2'b10, 1'b1, 16'h0000, 1'b1, acc);
    drain();
    issue(16'h0000, 16'h0000, 2'b11, 1'b0, 16'hFFFF, 1'b0, acc);
    drain();
    issue(16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, acc);
    drain();

    // Backpressure with an ignored request in DONE
    res_ready = 1'b0;
    issue(16'h0A0B, 16'h0102, 2'b00, 1'b0, 16'h0B0D, 1'b0, acc);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (res_valid) ok = 1'b1;
      end
      if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1;
      in_valid = (i == 1);
      op_a = 16'h5555; op_b = 16'h3333;
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_sum", res_sum, 16'h0B0D);
      chk("bp_res_cout", res_cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drop", res_valid, 0);
    repeat (20) @(negedge clk);
    chk("bp_no_queue", res_valid, 0);

    // Mid-operation reset during nibble 2 settle
    issue(16'h1234, 16'h0FFF, 2'b01, 1'b1, 16'h0000, 1'b0, acc);
    repeat (7) @(negedge clk);
    chk("mid_nib2", add_a, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_sum", res_sum, 0);
    chk("mrst_res_cout", res_cout, 0);
    chk("mrst_add_a", add_a, 0);
    chk("mrst_add_b", add_b, 0);
    chk("mrst_add_s", add_s, 0);
    chk("mrst_add_cin", add_cin, 0);
    op_a = 16'h00FF; op_b = 16'h0001; op_sel = 2'b00; op_cin = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    e.sum = 16'h0100; e.cout = 1'b0; e.cyc = cyc + 1 + 12;
    sb.push_back(e);
    @(posedge clk) #1;
    in_valid = 1'b0;
    drain();

    // Operand stability after accept
    issue(16'h1111, 16'h2222, 2'b00, 1'b1, 16'h3334, 1'b0, acc);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk) #1;
      op_a = 16'($urandom); op_b = 16'($urandom); op_sel = 2'($urandom); op_cin = 1'($urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
